mem_access_sequencer: RTL

Sequencer between the pipeline MEM stage and the byte-wide data RAM. Accepts one load/store request (byte, halfword, word, doubleword) and issues one RAM byte access per cycle at consecutive addresses. For loads, it assembles the returned bytes big-endian into a right-justified 64-bit result. It returns a single-cycle response with an out-of-range error flag, and it replaces the multi-byte read logic that used to live inside the RAM.

---
 rtl/mem_seq_pkg.sv | 29 ++
 rtl/mem_seq_assembler.sv | 63 ++++++
 rtl/mem_access_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory access sequencer: size encodings,
// FSM states and the size-to-byte-count mapping.
package mem_seq_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SZ_BYTE:  n = 4'd1;
            SZ_HALF:  n = 4'd2;
            SZ_WORD:  n = 4'd4;
            SZ_DWORD: n = 4'd8;
            default:  n = 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_seq_assembler.sv
// Load-data accumulator: bytes arrive most significant first and are shifted
// in from the right; the result is sign- or zero-extended from the top byte.
module mem_seq_assembler
    import mem_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    input  logic [3:0]  n,
    input  logic        signed_en,
    output logic [63:0] result
);

    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic        sign_bit;
    logic [63:0] fill_mask;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (shift_en) begin
            acc_d = {acc_q[55:0], byte_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Bits above 8N are already zero because the accumulator is cleared per request.
    always_comb begin
        sign_bit  = 1'b0;
        fill_mask = '0;
        case (n)
            4'd1: begin
                sign_bit  = acc_q[7];
                fill_mask = 64'hFFFF_FFFF_FFFF_FF00;
            end
            4'd2: begin
                sign_bit  = acc_q[15];
                fill_mask = 64'hFFFF_FFFF_FFFF_0000;
            end
            4'd4: begin
                sign_bit  = acc_q[31];
                fill_mask = 64'hFFFF_FFFF_0000_0000;
            end
            default: begin
                sign_bit  = 1'b0;
                fill_mask = '0;
            end
        endcase
        result = (signed_en && sign_bit) ? (acc_q | fill_mask) : acc_q;
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Splits one load/store request into consecutive byte accesses on the data RAM
// and returns a single-cycle response, assembling load bytes big-endian.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [63:0]       rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        n_q, n_d;
    logic              write_q, write_d;
    logic              signed_q, signed_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              rd_pend_q, rd_pend_d;

    logic [3:0]        req_n;
    logic [MEM_AW:0]   req_end;
    logic              req_err;
    logic [2:0]        last_idx;
    logic              asm_clr;
    logic [63:0]       asm_result;

    function automatic logic [7:0] byte_sel(input logic [63:0] d, input logic [2:0] idx);
        return d[{idx, 3'b000} +: 8];
    endfunction

    assign req_n    = size_to_bytes(req_size);
    // End address computed one bit wider so a carry out flags a run past the top of RAM.
    assign req_end  = {1'b0, req_addr[MEM_AW-1:0]} + (MEM_AW+1)'(req_n) - (MEM_AW+1)'(1);
    assign req_err  = (|req_addr[ADDR_W-1:MEM_AW]) | req_end[MEM_AW];
    assign last_idx = 3'(n_q - 4'd1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        write_d     = write_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = 8'h00;
        rsp_valid_d = 1'b0;
        asm_clr     = 1'b0;
        rd_pend_d   = mem_en_q & ~mem_we_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    n_d      = req_n;
                    write_d  = req_write;
                    signed_d = req_signed;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    cnt_d    = 3'd0;
                    asm_clr  = 1'b1;
                    if (req_err) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = req_addr[MEM_AW-1:0];
                        mem_wdata_d = req_write ? byte_sel(req_wdata, 3'(req_n - 4'd1)) : 8'h00;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == last_idx) begin
                    if (write_q) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    cnt_d       = cnt_q + 3'd1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = write_q;
                    mem_addr_d  = mem_addr_q + MEM_AW'(1);
                    mem_wdata_d = write_q ? byte_sel(wdata_q, last_idx - cnt_d) : 8'h00;
                end
            end
            ST_WAIT: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            write_q     <= write_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    // Each read byte arrives one cycle after its strobe, so the shift trails mem_en by one.
    mem_seq_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (asm_clr),
        .shift_en  (rd_pend_q),
        .byte_in   (mem_rdata),
        .n         (n_q),
        .signed_en (signed_q),
        .result    (asm_result)
    );

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q & err_q;
    assign rsp_rdata = (rsp_valid_q && !err_q && !write_q) ? asm_result : 64'h0;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
